// File: rtl/sr_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_drv_pkg
// Description : Shared types and constants for the SR latch driver.
//               FSM state encoding, command opcodes and the read-back
//               check used when the latch result is reported.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_drv_pkg;

    // Driver FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } drv_state_t;

    // Command opcodes carried on cmd_op
    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

    // A result is bad if Q disagrees with the command, or if Q and Qbar
    // read the same level (a latch stuck or never properly resolved).
    function automatic logic check_fail(input logic q_s,
                                        input logic qbar_s,
                                        input logic op);
        return (q_s != op) | (q_s == qbar_s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_driver_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for one asynchronous level signal.
//               Both flops clear to 0 on synchronous active-low reset.
// Ports       : clock   - rising-edge clock
//               reset_n - synchronous active-low reset
//               i_d     - asynchronous input
//               o_q     - synchronised output (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2
    import sr_drv_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_driver
// Description : Clocked driver for an asynchronous active-low SR latch.
//               Accepts set/reset commands, pulses Sbar or Rbar low for
//               PULSE_W cycles, lets the latch and synchronisers settle,
//               then reports the read-back Q and an error flag.
// Ports       : clock      - rising-edge clock
//               reset_n    - synchronous active-low reset
//               cmd_valid  - command request
//               cmd_ready  - driver idle, command accepted on valid&ready
//               cmd_op     - 1 = set (pulse Sbar), 0 = reset (pulse Rbar)
//               latch_sbar - to latch Sbar (registered, active low)
//               latch_rbar - to latch Rbar (registered, active low)
//               latch_q    - from latch Q (asynchronous)
//               latch_qbar - from latch Qbar (asynchronous)
//               done_valid - one-cycle result strobe
//               done_q     - synchronised Q sampled at the check
//               done_err   - read-back check failure
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 2,
    parameter int CNT_W    = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_op,
    output logic latch_sbar,
    output logic latch_rbar,
    input  logic latch_q,
    input  logic latch_qbar,
    output logic done_valid,
    output logic done_q,
    output logic done_err
);

    // Phase lengths; the settle phase adds 2 cycles so the read-back has
    // passed through both synchroniser flops before it is sampled.
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_pulse_ld  = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] c_settle_ld = CNT_W'(SETTLE_W + 2);

    drv_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;

    logic             w_q_s;
    logic             w_qbar_s;

    sync2 u_sync_q (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (latch_q),
        .o_q     (w_q_s)
    );

    sync2 u_sync_qbar (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (latch_qbar),
        .o_q     (w_qbar_s)
    );

    // Single registered FSM. Sbar and Rbar are only ever driven low from
    // the IDLE accept branch, which selects exactly one of them from
    // cmd_op, so both can never be low together. Reset forces both high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= OP_RESET;
            latch_sbar <= 1'b1;
            latch_rbar <= 1'b1;
            cmd_ready  <= 1'b1;
            done_valid <= 1'b0;
            done_q     <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state    <= PULSE;
                        r_op       <= cmd_op;
                        r_cnt      <= c_pulse_ld;
                        cmd_ready  <= 1'b0;
                        latch_sbar <= (cmd_op != OP_SET);
                        latch_rbar <= (cmd_op != OP_RESET);
                    end
                end

                PULSE: begin
                    if (r_cnt == c_cnt_one) begin
                        r_state    <= SETTLE;
                        r_cnt      <= c_settle_ld;
                        latch_sbar <= 1'b1;
                        latch_rbar <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                SETTLE: begin
                    if (r_cnt == c_cnt_one) begin
                        r_state    <= CHECK;
                        done_valid <= 1'b1;
                        done_q     <= w_q_s;
                        done_err   <= check_fail(w_q_s, w_qbar_s, r_op);
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                CHECK: begin
                    r_state    <= IDLE;
                    done_valid <= 1'b0;
                    cmd_ready  <= 1'b1;
                end

                default: begin
                    r_state    <= IDLE;
                    latch_sbar <= 1'b1;
                    latch_rbar <= 1'b1;
                    cmd_ready  <= 1'b1;
                    done_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_latch_driver
// Description : Self-checking bench for sr_latch_driver. Two instances:
//               PULSE_W=4/SETTLE_W=2 and PULSE_W=1/SETTLE_W=0, each wired
//               to a behavioural SR latch. A timing model derived from the
//               accept edge predicts every output each cycle; directed
//               commands pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_driver;

    localparam int PW [2] = '{4, 1};
    localparam int SW [2] = '{2, 0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic cmd_valid [2];
    logic cmd_op    [2];
    logic force_en  [2];
    logic force_q   [2];
    logic force_qbar[2];

    wire  cmd_ready [2];
    wire  sbar      [2];
    wire  rbar      [2];
    wire  q_in      [2];
    wire  qbar_in   [2];
    wire  done_valid[2];
    wire  done_q    [2];
    wire  done_err  [2];

    for (genvar gd = 0; gd < 2; gd++) begin : g_env
        // Behavioural active-low SR latch, starts out reset
        logic lq = 1'b0;
        always @(sbar[gd] or rbar[gd]) begin
            if (sbar[gd] === 1'b0 && rbar[gd] === 1'b1)      lq = 1'b1;
            else if (sbar[gd] === 1'b1 && rbar[gd] === 1'b0) lq = 1'b0;
        end
        assign q_in[gd]    = force_en[gd] ? force_q[gd]    : lq;
        assign qbar_in[gd] = force_en[gd] ? force_qbar[gd] : ~lq;

        sr_latch_driver #(
            .PULSE_W  (PW[gd]),
            .SETTLE_W (SW[gd]),
            .CNT_W    (8)
        ) u_dut (
            .clock      (clk),
            .reset_n    (rst_n),
            .cmd_valid  (cmd_valid[gd]),
            .cmd_ready  (cmd_ready[gd]),
            .cmd_op     (cmd_op[gd]),
            .latch_sbar (sbar[gd]),
            .latch_rbar (rbar[gd]),
            .latch_q    (q_in[gd]),
            .latch_qbar (qbar_in[gd]),
            .done_valid (done_valid[gd]),
            .done_q     (done_q[gd]),
            .done_err   (done_err[gd])
        );
    end

    // ------------------------------------------------------------------
    // Model: per DUT, the edge index of the last accept and its opcode.
    // Expected outputs follow from edge arithmetic relative to that edge.
    // ------------------------------------------------------------------
    int ecount = 0;
    bit m_active[2];
    int m_k     [2];
    bit m_op    [2];
    bit m_stored[2];
    int m_acc   [2];
    int m_done  [2];

    always @(posedge clk) begin
        ecount = ecount + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst_n !== 1'b1) begin
                m_active[d] = 1'b0;
            end else begin
                if (m_active[d] && (ecount - 1 >= m_k[d] + PW[d] + SW[d] + 3))
                    m_active[d] = 1'b0;
                if (!m_active[d] && cmd_valid[d] === 1'b1) begin
                    m_active[d] = 1'b1;
                    m_k[d]      = ecount;
                    m_op[d]     = cmd_op[d];
                    m_stored[d] = cmd_op[d];
                    m_acc[d]    = m_acc[d] + 1;
                end
                if (m_active[d] && ecount == m_k[d] + PW[d] + SW[d] + 2)
                    m_done[d] = m_done[d] + 1;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;
    int dv_seen[2];

    task automatic chk(input string name, input int d, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %b expected %b (edge %0d)", name, d, act, exp, ecount);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic low, e_sbar, e_rbar, e_rdy, e_dv, qx, qbx;
                if (m_active[d]) begin
                    low    = (ecount >= m_k[d]) && (ecount < m_k[d] + PW[d]);
                    e_sbar = !(low && m_op[d]);
                    e_rbar = !(low && !m_op[d]);
                    e_dv   = (ecount == m_k[d] + PW[d] + SW[d] + 2);
                    e_rdy  = (ecount >= m_k[d] + PW[d] + SW[d] + 3);
                end else begin
                    e_sbar = 1'b1;
                    e_rbar = 1'b1;
                    e_dv   = 1'b0;
                    e_rdy  = 1'b1;
                end
                chk("never_both_low", d, (sbar[d] === 1'b0 && rbar[d] === 1'b0), 1'b0);
                chk("latch_sbar", d, sbar[d], e_sbar);
                chk("latch_rbar", d, rbar[d], e_rbar);
                chk("cmd_ready", d, cmd_ready[d], e_rdy);
                chk("done_valid", d, done_valid[d], e_dv);
                if (done_valid[d] === 1'b1) dv_seen[d]++;
                if (e_dv) begin
                    qx  = force_en[d] ? force_q[d]    : m_stored[d];
                    qbx = force_en[d] ? force_qbar[d] : !m_stored[d];
                    chk("done_q", d, done_q[d], qx);
                    chk("done_err", d, done_err[d], (qx != m_op[d]) || (qx == qbx));
                end
            end
        end
    endtask

    // Issue one command from a negedge and observe it until done_valid.
    // With hold=1, cmd_valid stays high after accept carrying next_op.
    task automatic do_cmd(input int d, input logic op, input logic hold, input logic next_op,
                          output int acc_e, output int low_n, output int dv_off,
                          output logic dq, output logic de);
        int t;
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        t = 0;
        while (cmd_ready[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_total++;
            $display("FAIL cmd_ready_timeout dut%0d: got 0 expected 1 within 100 cycles", d);
        end
        @(posedge clk);
        #1;
        acc_e  = ecount;
        low_n  = 0;
        dv_off = -1;
        dq     = 1'bx;
        de     = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_valid[d] = hold;
                cmd_op[d]    = next_op;
            end
            if ((op ? sbar[d] : rbar[d]) === 1'b0) low_n++;
            if (done_valid[d] === 1'b1) begin
                dv_off = ecount - acc_e;
                dq     = done_q[d];
                de     = done_err[d];
                break;
            end
        end
        if (dv_off < 0) begin
            n_total++;
            $display("FAIL done_timeout dut%0d: got none expected done_valid within 60 cycles", d);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int ae, ae2, ln, dvo, dvc, a0, a1, cyc;
        logic dq, de;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d]  = 1'b0;
            cmd_op[d]     = 1'b0;
            force_en[d]   = 1'b0;
            force_q[d]    = 1'b0;
            force_qbar[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state, pinned with literals
        chk("rst_sbar", 0, sbar[0], 1'b1);
        chk("rst_rbar", 0, rbar[0], 1'b1);
        chk("rst_ready", 0, cmd_ready[0], 1'b1);
        chk("rst_done_valid", 0, done_valid[0], 1'b0);
        chk("rst_done_q", 0, done_q[0], 1'b0);
        chk("rst_done_err", 0, done_err[0], 1'b0);
        rst_n = 1'b1;

        fork
            compare_loop();
        join_none

        idle_cycles(2);

        // Single set command: 4-cycle Sbar pulse, done 8 edges after accept
        do_cmd(0, 1'b1, 1'b0, 1'b0, ae, ln, dvo, dq, de);
        chk_int("set_pulse_len", ln, 4);
        chk_int("set_done_offset", dvo, 8);
        chk("set_done_q", 0, dq, 1'b1);
        chk("set_done_err", 0, de, 1'b0);

        // Repeated set while set, then reset with cmd_valid held throughout
        do_cmd(0, 1'b1, 1'b1, 1'b0, ae, ln, dvo, dq, de);
        chk("reset_set_err", 0, de, 1'b0);
        do_cmd(0, 1'b0, 1'b0, 1'b0, ae2, ln, dvo, dq, de);
        chk_int("b2b_accept_gap", ae2 - ae, 10);
        chk_int("reset_pulse_len", ln, 4);
        chk("reset_done_q", 0, dq, 1'b0);
        chk("reset_done_err", 0, de, 1'b0);

        // Forced fault: Q and Qbar both read high
        force_en[0] = 1'b1; force_q[0] = 1'b1; force_qbar[0] = 1'b1;
        idle_cycles(3);
        do_cmd(0, 1'b1, 1'b0, 1'b0, ae, ln, dvo, dq, de);
        chk("fault_both_high_err", 0, de, 1'b1);
        // Forced fault: Q stuck high on a reset command
        force_qbar[0] = 1'b0;
        idle_cycles(3);
        do_cmd(0, 1'b0, 1'b0, 1'b0, ae, ln, dvo, dq, de);
        chk("fault_q_stuck_err", 0, de, 1'b1);
        chk("fault_q_stuck_q", 0, dq, 1'b1);
        force_en[0] = 1'b0;
        idle_cycles(3);

        // Reset asserted during the second PULSE cycle of a set
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 1'b1;
        while (cmd_ready[0] !== 1'b1) @(negedge clk);
        @(negedge clk);          // accepted; first PULSE cycle
        cmd_valid[0] = 1'b0;
        @(negedge clk);          // second PULSE cycle
        chk("abort_pulse_low", 0, sbar[0], 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_sbar_high", 0, sbar[0], 1'b1);
        chk("abort_ready", 0, cmd_ready[0], 1'b1);
        rst_n = 1'b1;
        dvc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_valid[0] === 1'b1) dvc++;
        end
        chk_int("abort_no_done", dvc, 0);

        // Short configuration: 1-cycle pulse, done 3 edges after accept
        do_cmd(1, 1'b1, 1'b0, 1'b0, ae, ln, dvo, dq, de);
        chk_int("short_set_pulse_len", ln, 1);
        chk_int("short_set_done_offset", dvo, 3);
        chk("short_set_q", 1, dq, 1'b1);
        chk("short_set_err", 1, de, 1'b0);
        do_cmd(1, 1'b0, 1'b0, 1'b0, ae, ln, dvo, dq, de);
        chk_int("short_reset_pulse_len", ln, 1);
        chk("short_reset_q", 1, dq, 1'b0);
        chk("short_reset_err", 1, de, 1'b0);

        // Random commands with random gaps on both instances
        a0  = m_acc[0];
        a1  = m_acc[1];
        cyc = 0;
        while ((m_acc[0] - a0 < 200 || m_acc[1] - a1 < 200) && cyc < 20000) begin
            for (int d = 0; d < 2; d++) begin
                cmd_valid[d] = ($urandom_range(0, 2) == 0);
                cmd_op[d]    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        chk_int("random_cycle_budget", (cyc < 20000) ? 1 : 0, 1);
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
        idle_cycles(20);

        // Every completed accept yielded exactly one done strobe
        chk_int("done_count_dut0", dv_seen[0], m_done[0]);
        chk_int("done_count_dut1", dv_seen[1], m_done[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
